// File: rtl/multicycle_control.sv
// Moore control unit for a multicycle MIPS-style datapath (fetch, decode, lw/sw, R-type, beq, j, addi).
// The control vector is decoded from the next state and registered together with the state register.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opCode,
  output logic       PCWriteCond,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [3:0] state,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_IF0  = 4'd0,
    S_IF1  = 4'd1,
    S_ID   = 4'd2,
    S_MA   = 4'd3,
    S_MR0  = 4'd4,
    S_MR1  = 4'd5,
    S_MW   = 4'd6,
    S_EX   = 4'd7,
    S_RW   = 4'd8,
    S_BR   = 4'd9,
    S_JMP  = 4'd10,
    S_AI   = 4'd11,
    S_AW   = 4'd12,
    S_HALT = 4'd13
  } state_e;

  typedef struct packed {
    logic       pc_write_cond;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_e state_r;
  state_e next_state_s;
  ctrl_t  ctrl_r;

  // Per-state control vector; anything not set for a state stays 0 (including codes 14/15).
  function automatic ctrl_t decode_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_IF0: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_IF1: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
      end
      S_ID: begin
        c.alu_src_b = 2'b11;
      end
      S_MA: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MR0: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.i_or_d    = 1'b1;
        c.mem_read  = 1'b1;
      end
      S_MR1: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = 2'b10;
        c.i_or_d     = 1'b1;
        c.mem_read   = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MW: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.i_or_d    = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_RW: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BR: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_AI: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_AW: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.reg_write = 1'b1;
      end
      S_HALT: begin
        c.halted = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  // Next-state logic; opCode only matters in ID and MA.
  always_comb begin
    next_state_s = S_IF0;
    case (state_r)
      S_IF0: next_state_s = S_IF1;
      S_IF1: next_state_s = S_ID;
      S_ID: begin
        case (opCode)
          OP_LW, OP_SW: next_state_s = S_MA;
          OP_RTYPE:     next_state_s = S_EX;
          OP_BEQ:       next_state_s = S_BR;
          OP_J:         next_state_s = S_JMP;
          OP_ADDI:      next_state_s = S_AI;
          default:      next_state_s = S_HALT;
        endcase
      end
      S_MA: begin
        if (opCode == OP_LW) begin
          next_state_s = S_MR0;
        end else begin
          next_state_s = S_MW;
        end
      end
      S_MR0:  next_state_s = S_MR1;
      S_MR1:  next_state_s = S_IF0;
      S_MW:   next_state_s = S_IF0;
      S_EX:   next_state_s = S_RW;
      S_RW:   next_state_s = S_IF0;
      S_BR:   next_state_s = S_IF0;
      S_JMP:  next_state_s = S_IF0;
      S_AI:   next_state_s = S_AW;
      S_AW:   next_state_s = S_IF0;
      S_HALT: next_state_s = S_HALT;
      default: next_state_s = S_IF0;
    endcase
  end

  // State and control registers; reset lands directly on the IF0 vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IF0;
      ctrl_r  <= decode_ctrl(S_IF0);
    end else begin
      state_r <= next_state_s;
      ctrl_r  <= decode_ctrl(next_state_s);
    end
  end

  assign state       = state_r;
  assign PCWriteCond = ctrl_r.pc_write_cond;
  assign PCWrite     = ctrl_r.pc_write;
  assign IorD        = ctrl_r.i_or_d;
  assign MemRead     = ctrl_r.mem_read;
  assign MemWrite    = ctrl_r.mem_write;
  assign MemtoReg    = ctrl_r.mem_to_reg;
  assign IRWrite     = ctrl_r.ir_write;
  assign ALUSrcA     = ctrl_r.alu_src_a;
  assign RegWrite    = ctrl_r.reg_write;
  assign RegDst      = ctrl_r.reg_dst;
  assign PCSource    = ctrl_r.pc_source;
  assign ALUSrcB     = ctrl_r.alu_src_b;
  assign ALUOp       = ctrl_r.alu_op;
  assign halted      = ctrl_r.halted;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level reference model with random opcodes,
// random mid-instruction resets, and a few literal sequences that pin the model.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opCode = 6'd0;
  logic       PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst, halted;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [3:0] state;
  logic [16:0] dut_ctrl;

  int checks = 0;
  int errors = 0;
  int exp_state = 0;
  int q[$];
  logic [5:0] instr = 6'd0;
  int force_op = -1;
  bit chk_en = 1'b0;

  logic [5:0] d_op[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
  int d_len[6] = '{6, 7, 6, 5, 5, 6};
  int d_seq[6][7] = '{'{0,1,2,7,8,0,0}, '{0,1,2,3,4,5,0}, '{0,1,2,3,6,0,0},
                      '{0,1,2,9,0,0,0}, '{0,1,2,10,0,0,0}, '{0,1,2,11,12,0,0}};
  int d_rw[6] = '{1, 1, 0, 0, 0, 1};
  int d_mw[6] = '{0, 0, 1, 0, 0, 0};

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opCode(opCode),
    .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .state(state), .halted(halted)
  );

  assign dut_ctrl = {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                     ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, halted};

  // Control vector each state must show, written as "which states assert this signal".
  function automatic logic [16:0] exp_ctrl(input int s);
    logic [1:0] pcsrc, srcb, aluop;
    pcsrc = (s == 9) ? 2'd1 : (s == 10) ? 2'd2 : 2'd0;
    srcb  = (s == 0 || s == 1) ? 2'd1 : (s == 2) ? 2'd3 :
            (s inside {3, 4, 5, 6, 11, 12}) ? 2'd2 : 2'd0;
    aluop = (s == 7 || s == 8) ? 2'd2 : (s == 9) ? 2'd1 : 2'd0;
    return {s == 9, s inside {1, 10}, s inside {4, 5, 6}, s inside {0, 1, 4, 5}, s == 6,
            s == 5, s == 1, s inside {3, 4, 5, 6, 7, 8, 9, 11, 12}, s inside {5, 8, 12},
            s == 8, pcsrc, srcb, aluop, s == 13};
  endfunction

  function automatic logic [5:0] pick_op();
    int r;
    logic [5:0] op;
    r = $urandom_range(0, 15);
    if (r < 3)       op = 6'b100011;
    else if (r < 5)  op = 6'b101011;
    else if (r < 8)  op = 6'b000000;
    else if (r < 10) op = 6'b000100;
    else if (r < 12) op = 6'b000010;
    else if (r < 15) op = 6'b001000;
    else begin
      op = 6'($urandom_range(0, 63));
      if (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000})
        op = 6'b111111;
    end
    return op;
  endfunction

  // Instruction-level model: on leaving IF0, queue the whole state walk of the new instruction.
  task automatic advance();
    if (exp_state == 13) return;
    if (q.size() == 0) begin
      instr = (force_op >= 0) ? force_op[5:0] : pick_op();
      case (instr)
        6'b100011: q = '{1, 2, 3, 4, 5, 0};
        6'b101011: q = '{1, 2, 3, 6, 0};
        6'b000000: q = '{1, 2, 7, 8, 0};
        6'b001000: q = '{1, 2, 11, 12, 0};
        6'b000100: q = '{1, 2, 9, 0};
        6'b000010: q = '{1, 2, 10, 0};
        default:   q = '{1, 2, 13};
      endcase
    end
    exp_state = q.pop_front();
  endtask

  task automatic cycle();
    if (exp_state == 2 || exp_state == 3) opCode = instr;
    else opCode = 6'($urandom_range(0, 63));
    @(posedge clk);
    #1;
    advance();
  endtask

  // Reset asserted between edges must take effect without waiting for a clock.
  task automatic reset_pulse(input int hold);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || dut_ctrl !== exp_ctrl(0)) begin
      errors++;
      $display("FAIL async_rst state=%0d ctrl=%h want state=0 ctrl=%h", state, dut_ctrl, exp_ctrl(0));
    end
    exp_state = 0;
    q.delete();
    repeat (hold) begin
      @(posedge clk);
      #1;
      checks++;
      if (state !== 4'd0) begin
        errors++;
        $display("FAIL rst_hold state=%0d want 0", state);
      end
    end
    #2 reset = 1'b0;
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (state !== 4'(exp_state) || dut_ctrl !== exp_ctrl(exp_state)) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t state=%0d ctrl=%h want state=%0d ctrl=%h",
                 $time, state, dut_ctrl, exp_state, exp_ctrl(exp_state));
      end
    end
  end

  initial begin
    int rw, mw, bound, held, halt_cnt, halt_lim;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (state !== 4'd0 || MemRead !== 1'b1 || ALUSrcB !== 2'b01 || RegWrite !== 1'b0 ||
        MemWrite !== 1'b0 || PCWrite !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL rst_vals state=%0d MemRead=%b ALUSrcB=%b RegWrite=%b halted=%b want 0/1/01/0/0",
               state, MemRead, ALUSrcB, RegWrite, halted);
    end
    chk_en = 1'b1;
    #2 reset = 1'b0;

    // Literal instruction walks.
    for (int k = 0; k < 6; k++) begin
      force_op = int'(d_op[k]);
      rw = 0;
      mw = 0;
      for (int i = 0; i < d_len[k]; i++) begin
        checks++;
        if (state !== 4'(d_seq[k][i])) begin
          errors++;
          $display("FAIL seq op=%b step=%0d state=%0d want %0d", d_op[k], i, state, d_seq[k][i]);
        end
        if (i == 3 && (k == 3 || k == 4)) begin
          checks++;
          if ({PCWriteCond, PCWrite, PCSource} !== ((k == 3) ? 4'b1001 : 4'b0110)) begin
            errors++;
            $display("FAIL pc_ctrl op=%b got=%b want=%b", d_op[k], {PCWriteCond, PCWrite, PCSource},
                     (k == 3) ? 4'b1001 : 4'b0110);
          end
        end
        if (i < d_len[k] - 1) begin
          rw += int'(RegWrite);
          mw += int'(MemWrite);
          cycle();
        end
      end
      checks++;
      if (rw != d_rw[k] || mw != d_mw[k]) begin
        errors++;
        $display("FAIL we_count op=%b RegWrite=%0d MemWrite=%0d want %0d/%0d", d_op[k], rw, mw, d_rw[k], d_mw[k]);
      end
    end

    // Illegal opcode: HALT must hold for well over 20 cycles.
    force_op = 63;
    bound = 0;
    while (exp_state != 13 && bound < 10) begin
      cycle();
      bound++;
    end
    held = 0;
    repeat (22) begin
      cycle();
      held += int'(halted);
    end
    checks++;
    if (held != 22 || state !== 4'd13) begin
      errors++;
      $display("FAIL halt_hold halted_cycles=%0d state=%0d want 22/13", held, state);
    end
    reset_pulse(2);

    // lw interrupted by reset while in MA.
    force_op = 35;
    bound = 0;
    while (exp_state != 3 && bound < 10) begin
      cycle();
      bound++;
    end
    checks++;
    if (state !== 4'd3) begin
      errors++;
      $display("FAIL reach_ma state=%0d want 3", state);
    end
    reset_pulse(1);

    // Random traffic.
    force_op = -1;
    halt_cnt = 0;
    halt_lim = $urandom_range(2, 25);
    repeat (3000) begin
      cycle();
      if (exp_state == 13) begin
        halt_cnt++;
        if (halt_cnt > halt_lim) begin
          reset_pulse($urandom_range(1, 3));
          halt_cnt = 0;
          halt_lim = $urandom_range(2, 25);
        end
      end else if ($urandom_range(0, 59) == 0) begin
        reset_pulse($urandom_range(1, 3));
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
